// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry, writeback grant-source codes, r0.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Which source owns the register-file write port this cycle
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_PIPE = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;
    localparam logic [1:0] SRC_MD   = 2'd3;

    // Writes addressed here complete their handshake but never reach the file
    localparam logic [REG_ADDR_W-1:0] REG_R0 = '0;

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Counts consecutive cycles a secondary writeback waits and raises a registered pipeline stall.
// Latency: stall_pipe rises one cycle after the STARVE_LIMIT-th waiting cycle and drops one cycle after a secondary grant.
// Backpressure: none; this block only observes request/grant.
module rf_wb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sec_req,
    input  logic sec_gnt,
    output logic stall_pipe
);

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       stall_q, stall_d;
    logic       incr;

    // Next-state: count waiting cycles (saturating), arm stall on the last step before the limit
    always_comb begin
        incr       = sec_req & ~sec_gnt;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        if (sec_gnt || !sec_req) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        if (sec_gnt) begin
            stall_d = 1'b0;
        end else if (incr && (wait_cnt_q == LIMIT_M1)) begin
            stall_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            stall_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign stall_pipe = stall_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline first, then mem-load / mul-div round-robin, with anti-starvation stall.
// Latency: grant and rf write are combinational (same cycle); stall_pipe and err_stall_viol are registered.
// Backpressure: pipeline is never backpressured; secondaries see ready only in the cycle they are written.
// Optional: RF_WB_ARB_FWD_EN adds write-to-read forwarding for the two async read ports.
module rf_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_wa,
    input  logic [DATA_W-1:0]     pipe_wd,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_wa,
    input  logic [DATA_W-1:0]     mem_wd,
    output logic                  mem_ready,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_wa,
    input  logic [DATA_W-1:0]     md_wd,
    output logic                  md_ready,
`ifdef RF_WB_ARB_FWD_EN
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0]     rf_rd1,
    input  logic [DATA_W-1:0]     rf_rd2,
    output logic [DATA_W-1:0]     fwd_rd1,
    output logic [DATA_W-1:0]     fwd_rd2,
`endif
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]     rf_wd,
    output logic                  stall_pipe,
    output logic                  err_stall_viol
);

    logic [1:0] gnt_src;
    logic       rr_last_q, rr_last_d;   // 0 = mem granted last, 1 = md granted last
    logic       err_q, err_d;
    logic       sec_gnt;

    // Grant select: pipeline, then a lone secondary, then the secondary not served last
    always_comb begin
        gnt_src = SRC_NONE;
        if (rst) begin
            gnt_src = SRC_NONE;
        end else if (pipe_we) begin
            gnt_src = SRC_PIPE;
        end else if (mem_valid && md_valid) begin
            gnt_src = rr_last_q ? SRC_MEM : SRC_MD;
        end else if (mem_valid) begin
            gnt_src = SRC_MEM;
        end else if (md_valid) begin
            gnt_src = SRC_MD;
        end
    end

    // Write-port mux and handshake outputs; address/data are zero when idle
    always_comb begin
        rf_wa     = '0;
        rf_wd     = '0;
        mem_ready = 1'b0;
        md_ready  = 1'b0;
        case (gnt_src)
            SRC_PIPE: begin
                rf_wa = pipe_wa;
                rf_wd = pipe_wd;
            end
            SRC_MEM: begin
                rf_wa     = mem_wa;
                rf_wd     = mem_wd;
                mem_ready = 1'b1;
            end
            SRC_MD: begin
                rf_wa    = md_wa;
                rf_wd    = md_wd;
                md_ready = 1'b1;
            end
            default: begin
                rf_wa = '0;
                rf_wd = '0;
            end
        endcase
        rf_we = (gnt_src != SRC_NONE) && (rf_wa != REG_R0);
    end

    assign sec_gnt = mem_ready | md_ready;

    // Next-state for round-robin pointer and sticky stall-violation flag
    always_comb begin
        rr_last_d = rr_last_q;
        if (sec_gnt) begin
            rr_last_d = md_ready;
        end
        err_d = err_q | (pipe_we & stall_pipe);
    end

    // Arbiter state registers; reset makes mem win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    assign err_stall_viol = err_q;

    rf_wb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .sec_req    (mem_valid | md_valid),
        .sec_gnt    (sec_gnt),
        .stall_pipe (stall_pipe)
    );

`ifdef RF_WB_ARB_FWD_EN
    // Bypass the write landing this cycle onto the async read ports
    always_comb begin
        fwd_rd1 = (rf_we && (rf_wa == ra1)) ? rf_wd : rf_rd1;
        fwd_rd2 = (rf_we && (rf_wa == ra2)) ? rf_wd : rf_rd2;
    end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Arbitrates the single register-file write port (we/wa/wd) among three writeback sources: the pipeline writeback stage, the slow memory-load return path, and the multi-cycle mul/div unit.
- The pipeline always has priority.
- Secondary sources share the remaining slots round-robin. A starvation counter forces a pipeline bubble when a secondary source waits too long.
- Sits between the writeback sources and the register file in the CPU top level.

Parameters:
- STARVE_LIMIT, 4, consecutive waiting cycles of any secondary request before a pipeline stall is requested (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pipe_we  in  1  pipeline writeback valid (no backpressure)
- pipe_wa  in  5  pipeline destination register
- pipe_wd  in  32  pipeline write data
- mem_valid  in  1  load-return write request
- mem_wa  in  5  load destination register
- mem_wd  in  32  load data
- mem_ready  out  1  load write accepted this cycle
- md_valid  in  1  mul/div write request
- md_wa  in  5  mul/div destination register
- md_wd  in  32  mul/div result
- md_ready  out  1  mul/div write accepted this cycle
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data
- stall_pipe  out  1  request: pipeline must present pipe_we=0 next cycle
- err_stall_viol  out  1  sticky: pipe_we seen while stall_pipe=1

Behaviour:
- Grant is combinational, same cycle, evaluated in this order:
  - If pipe_we=1, pipe wins.
  - Else if only one secondary source is valid, that source wins.
  - Else if both secondaries are valid, rr_last decides: the source not granted last wins.
- Handshake:
  - A secondary write completes on the cycle where valid & ready.
  - The requester holds valid, wa and wd stable until that cycle.
  - ready is never asserted without valid.
- Outputs:
  - rf_wa and rf_wd come from the granted source; both are 0 when nothing is granted.
  - rf_we = granted & (wa != 0).
  - A write to r0 still completes the handshake, but rf_we stays 0.
- State registers:
  - rr_last (0=mem, 1=md): updated only on a secondary grant.
  - wait_cnt (4 bits): increments each cycle where (mem_valid|md_valid) and no secondary is granted; clears to 0 on any secondary grant or when no secondary is valid; saturates at STARVE_LIMIT.
  - stall_pipe (registered): set next cycle when wait_cnt==STARVE_LIMIT-1 and it is incrementing; cleared the cycle after a secondary grant.
- Stall semantics:
  - While stall_pipe=1 the pipeline is required to hold pipe_we=0, so a secondary is guaranteed a grant that cycle.
  - If pipe_we=1 anyway, pipe still wins (its data cannot be dropped) and err_stall_viol sets. err_stall_viol clears only on rst.
- Simultaneous events: a grant and a new request on the same cycle are handled independently; the next request is arbitrated on the next cycle.
- Reset (rst=1 at posedge):
  - rr_last=1, so mem wins the first tie.
  - wait_cnt=0, stall_pipe=0, err_stall_viol=0.
  - While rst is high, mem_ready, md_ready and rf_we are forced to 0.
  - Reset mid-handshake discards the pending request; the source must re-present it.

Optional Feature:
- Macro: RF_WB_ARB_FWD_EN.
- When defined, adds these ports:
  - ra1, ra2 (in, 5 each)
  - rf_rd1, rf_rd2 (in, 32, async register-file read data)
  - fwd_rd1, fwd_rd2 (out, 32)
- fwd_rdN = rf_wd when rf_we & (rf_wa == raN), else rf_rdN. This covers the same-cycle write-then-read window of the synchronous-write, async-read register file.
- When not defined, these ports and the logic do not exist.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_W=5, DATA_W=32
  - grant-source encoding constants SRC_NONE=0, SRC_PIPE=1, SRC_MEM=2, SRC_MD=3
  - the r0 constant
- One sub-module, rf_wb_starve_ctr, holds wait_cnt and the stall_pipe generation.
- Grant mux and round-robin stay in the top level.

Test Plan:
- Reset, then mem_valid=1, mem_wa=5, mem_wd=0x1234 with pipe idle -> mem_ready=1 same cycle; rf_we=1, rf_wa=5, rf_wd=0x1234.
- pipe_we=1 (wa=3, wd=0xA) and mem_valid=1 together -> rf_wa=3, mem_ready=0; mem is granted on the first cycle pipe_we=0.
- mem and md both valid for 4 pipe-idle cycles, each source re-presenting new data after every accept -> grant order mem, md, mem, md.
- STARVE_LIMIT=4, pipe_we=1 continuously, md_valid=1 -> stall_pipe=1 on the 5th cycle; with pipe_we dropped that cycle, md_ready=1; stall_pipe=0 on the next cycle.
- md_valid=1 with md_wa=0, md_wd=0xFFFF -> md_ready=1, rf_we=0.
- pipe_we=1 while stall_pipe=1 -> pipe granted, err_stall_viol=1 and held until rst. With RF_WB_ARB_FWD_EN defined: ra1=3 during a write to r3 of 0xBEEF -> fwd_rd1=0xBEEF.
